// File: rtl/addsub_pkg.sv
// Shared types and widths for the add/subtract result checker.
package addsub_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 5;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_ref.sv
// Reference model: expected 5-bit result of a 4-bit add or subtract.
module addsub_ref
    import addsub_pkg::*;
(
    input  logic             m,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] exp
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Subtract wraps mod 32, giving the 5-bit two's-complement difference.
    always_comb begin
        exp = a_ext + b_ext;
        if (m == MODE_SUB) begin
            exp = a_ext - b_ext;
        end
    end

endmodule

// File: rtl/addsub_checker.sv
// Checks observed adder/subtractor results against a reference, with
// saturating pass/fail counters, first-failure capture and optional halt.
module addsub_checker
    import addsub_pkg::*;
#(
    parameter int HALT_ON_ERR = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [RES_W-1:0] sum,
    output logic             res_valid,
    output logic             res_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             err,
    output logic             fail_m,
    output logic [OP_W-1:0]  fail_a,
    output logic [OP_W-1:0]  fail_b,
    output logic [RES_W-1:0] fail_sum,
    output logic [RES_W-1:0] fail_exp
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             s_valid;
    logic             s_m;
    logic [OP_W-1:0]  s_a;
    logic [OP_W-1:0]  s_b;
    logic [RES_W-1:0] s_sum;
    logic [RES_W-1:0] exp_val;
    logic             accept;
    logic             match;

    addsub_ref u_ref (
        .m   (s_m),
        .a   (s_a),
        .b   (s_b),
        .exp (exp_val)
    );

    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign match    = (s_sum == exp_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            s_valid    <= 1'b0;
            s_m        <= 1'b0;
            s_a        <= '0;
            s_b        <= '0;
            s_sum      <= '0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            err        <= 1'b0;
            fail_m     <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
            fail_exp   <= '0;
        end else begin
            s_valid <= accept && !clr;
            if (accept) begin
                s_m   <= m;
                s_a   <= a;
                s_b   <= b;
                s_sum <= sum;
            end

            // A result is still reported in a clr cycle, just not counted.
            res_valid <= s_valid;
            res_pass  <= s_valid && match;

            if (clr) begin
                state      <= RUN;
                pass_count <= '0;
                fail_count <= '0;
                err        <= 1'b0;
                fail_m     <= 1'b0;
                fail_a     <= '0;
                fail_b     <= '0;
                fail_sum   <= '0;
                fail_exp   <= '0;
            end else if (s_valid) begin
                if (match) begin
                    if (pass_count != CNT_MAX) begin
                        pass_count <= pass_count + 1'b1;
                    end
                end else begin
                    if (fail_count != CNT_MAX) begin
                        fail_count <= fail_count + 1'b1;
                    end
                    err <= 1'b1;
                    if (!err) begin
                        fail_m   <= s_m;
                        fail_a   <= s_a;
                        fail_b   <= s_b;
                        fail_sum <= s_sum;
                        fail_exp <= exp_val;
                    end
                    if (HALT_ON_ERR != 0) begin
                        state <= HALT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_checker.sv
// Directed bench: default, non-halting and 2-bit-counter checker instances.
module tb_addsub_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       m;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;

    logic       d_ready, d_rv, d_rp, d_err, d_fm;
    logic [7:0] d_pc, d_fc;
    logic [3:0] d_fa, d_fb;
    logic [4:0] d_fs, d_fe;

    logic       n_ready, n_rv, n_rp, n_err, n_fm;
    logic [7:0] n_pc, n_fc;
    logic [3:0] n_fa, n_fb;
    logic [4:0] n_fs, n_fe;

    logic       s_ready, s_rv, s_rp, s_err, s_fm;
    logic [1:0] s_pc, s_fc;
    logic [3:0] s_fa, s_fb;
    logic [4:0] s_fs, s_fe;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    addsub_checker dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .in_ready(d_ready), .m(m), .a(a), .b(b), .sum(sum),
        .res_valid(d_rv), .res_pass(d_rp), .pass_count(d_pc),
        .fail_count(d_fc), .err(d_err), .fail_m(d_fm), .fail_a(d_fa),
        .fail_b(d_fb), .fail_sum(d_fs), .fail_exp(d_fe)
    );

    addsub_checker #(.HALT_ON_ERR(0)) dut_nh (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .in_ready(n_ready), .m(m), .a(a), .b(b), .sum(sum),
        .res_valid(n_rv), .res_pass(n_rp), .pass_count(n_pc),
        .fail_count(n_fc), .err(n_err), .fail_m(n_fm), .fail_a(n_fa),
        .fail_b(n_fb), .fail_sum(n_fs), .fail_exp(n_fe)
    );

    addsub_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .in_ready(s_ready), .m(m), .a(a), .b(b), .sum(sum),
        .res_valid(s_rv), .res_pass(s_rp), .pass_count(s_pc),
        .fail_count(s_fc), .err(s_err), .fail_m(s_fm), .fail_a(s_fa),
        .fail_b(s_fb), .fail_sum(s_fs), .fail_exp(s_fe)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic mm, input logic [3:0] aa,
                         input logic [3:0] bb, input logic [4:0] ss);
        in_valid = 1'b1;
        m        = mm;
        a        = aa;
        b        = bb;
        sum      = ss;
    endtask

    task automatic do_clr();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        m = 1'b0; a = '0; b = '0; sum = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_ready", d_ready, 1);
        check("rst_rv", d_rv, 0);
        check("rst_rp", d_rp, 0);
        check("rst_pc", d_pc, 0);
        check("rst_fc", d_fc, 0);
        check("rst_err", d_err, 0);
        check("rst_fexp", d_fe, 0);

        // add pass, 1-cycle latency
        drive(1'b0, 4'd5, 4'd5, 5'b01010);
        step();
        in_valid = 1'b0;
        check("add_lat", d_rv, 0);
        step();
        check("add_rv", d_rv, 1);
        check("add_rp", d_rp, 1);
        check("add_pc", d_pc, 1);
        step();
        check("add_pulse", d_rv, 0);

        do_clr();
        check("clr_pc", d_pc, 0);

        // subtract with wrap, back to back
        drive(1'b1, 4'd0, 4'd2, 5'b11110);
        step();
        drive(1'b1, 4'b1010, 4'b0001, 5'b01001);
        step();
        in_valid = 1'b0;
        check("sub1_rv", d_rv, 1);
        check("sub1_rp", d_rp, 1);
        step();
        check("sub2_rv", d_rv, 1);
        check("sub2_rp", d_rp, 1);
        check("sub_pc", d_pc, 2);
        check("sub_err", d_err, 0);

        // mismatch with halt
        do_clr();
        drive(1'b0, 4'b1011, 4'b1011, 5'b00110);
        step();
        in_valid = 1'b0;
        step();
        check("mm_rv", d_rv, 1);
        check("mm_rp", d_rp, 0);
        check("mm_fc", d_fc, 1);
        check("mm_err", d_err, 1);
        check("mm_fexp", d_fe, 5'b10110);
        check("mm_fsum", d_fs, 5'b00110);
        check("mm_ready", d_ready, 0);
        drive(1'b0, 4'd1, 4'd1, 5'd2);
        repeat (3) step();
        in_valid = 1'b0;
        check("halt_rv", d_rv, 0);
        check("halt_pc", d_pc, 0);
        check("halt_fc", d_fc, 1);

        // no-halt instance: two mismatches then a pass
        do_clr();
        check("clr_ready", d_ready, 1);
        check("clr_err", d_err, 0);
        drive(1'b1, 4'd3, 4'd1, 5'd0);
        step();
        drive(1'b0, 4'd1, 4'd1, 5'd5);
        step();
        drive(1'b0, 4'd15, 4'd15, 5'd30);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("nh_fc", n_fc, 2);
        check("nh_pc", n_pc, 1);
        check("nh_fm", n_fm, 1);
        check("nh_fa", n_fa, 3);
        check("nh_fsum", n_fs, 0);
        check("nh_fexp", n_fe, 2);
        check("nh_ready", n_ready, 1);
        // halting instance: in-flight sample still counted, capture kept
        check("inflt_fc", d_fc, 2);
        check("inflt_pc", d_pc, 0);
        check("inflt_fa", d_fa, 3);
        check("inflt_fexp", d_fe, 2);

        // saturation
        do_clr();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'(i), 4'd1, 5'(i + 1));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("sat_pc", s_pc, 3);
        check("nosat_pc", d_pc, 5);

        // rst with a sample in flight
        drive(1'b0, 4'd1, 4'd1, 5'd0);
        step();
        drive(1'b0, 4'd2, 4'd3, 5'd5);
        step();
        in_valid = 1'b0;
        check("pre_rst_err", d_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_rv", d_rv, 0);
        check("rst_mid_pc", d_pc, 0);
        check("rst_mid_fc", d_fc, 0);
        check("rst_mid_err", d_err, 0);
        check("rst_mid_fexp", d_fe, 0);
        check("rst_mid_ready", d_ready, 1);
        step();
        check("rst_mid_rv2", d_rv, 0);

        // clr coincident with a reported result
        drive(1'b0, 4'd7, 4'd8, 5'd15);
        step();
        in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_res_rv", d_rv, 1);
        check("clr_res_rp", d_rp, 1);
        check("clr_res_pc", d_pc, 0);
        step();
        check("clr_res_pc2", d_pc, 0);

        // clr discards a sample accepted in the same cycle
        drive(1'b0, 4'd1, 4'd2, 5'd3);
        clr = 1'b1;
        step();
        in_valid = 1'b0;
        clr = 1'b0;
        check("clr_drop_rv", d_rv, 0);
        step();
        check("clr_drop_rv2", d_rv, 0);
        check("clr_drop_pc", d_pc, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addsub_checker.md
ADDSUB_CHECKER -- requirements
Module: addsub_checker

Interface
REQ-001 Parameter HALT_ON_ERR, default 1, meaning: 1 = stop accepting samples after the first mismatch.
REQ-002 Parameter CNT_W, default 8, meaning: width of the pass/fail counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clr  input  1  synchronous clear of counters, sticky flags and captured failure; returns the FSM to RUN.
REQ-006 in_valid  input  1  sample offered this cycle.
REQ-007 in_ready  output  1  checker can accept a sample.
REQ-008 m  input  1  mode of the observed operation: 0 = add, 1 = subtract.
REQ-009 a  input  4  operand a as applied to the adder/subtractor.
REQ-010 b  input  4  operand b as applied to the adder/subtractor.
REQ-011 sum  input  5  result observed at the adder/subtractor output.
REQ-012 res_valid  output  1  one-cycle pulse: a check result is reported this cycle.
REQ-013 res_pass  output  1  qualified by res_valid: 1 = match, 0 = mismatch.
REQ-014 pass_count  output  CNT_W  number of matching samples, saturating.
REQ-015 fail_count  output  CNT_W  number of mismatching samples, saturating.
REQ-016 err  output  1  sticky; set on the first mismatch.
REQ-017 fail_m, fail_a, fail_b, fail_sum, fail_exp  output  1/4/4/5/5  fields of the first failing sample, plus the expected value.

Function
REQ-018 A sample is accepted when in_valid and in_ready are both high on a rising edge.
REQ-019 Expected value: add = ({0,a} + {0,b}) mod 32; subtract = ({0,a} - {0,b}) mod 32, i.e. the 5-bit two's-complement difference.
- 1010 - 0001 gives 01001.
- 0000 - 0010 gives 11110.
REQ-020 Latency: res_valid, res_pass and the counter/err updates appear exactly 1 cycle after acceptance; the input sample is registered before comparison.
REQ-021 At most one result is produced per cycle; back-to-back accepted samples produce back-to-back res_valid pulses.
REQ-022 FSM states: RUN and HALT.
- RUN: in_ready = 1.
- HALT: in_ready = 0.
REQ-023 FSM transitions:
- RUN -> HALT when a mismatch is reported and HALT_ON_ERR = 1.
- HALT -> RUN only on clr.
- With HALT_ON_ERR = 0, the FSM stays in RUN.
REQ-024 In HALT, a sample already accepted in the cycle the mismatch is reported still completes and is counted. It does not overwrite the capture.
REQ-025 err sets on the first mismatch and stays set until clr or rst. The fail_* capture loads only when err is 0.
REQ-026 Counters saturate at 2^CNT_W - 1 and do not wrap.
REQ-027 clr coincident with a reported result:
- clr wins.
- The counters, err and the capture are cleared.
- The result is still pulsed on res_valid/res_pass but is not counted.
REQ-028 clr also discards any sample accepted in the same cycle; no res_valid follows it.

Reset
REQ-029 On rst, the following reset values apply:
- FSM = RUN, in_ready = 1.
- res_valid = 0, res_pass = 0.
- Both counters = 0, err = 0.
- All fail_* = 0.
- The internal sample register is invalid.
REQ-030 rst asserted while a sample is in flight: the sample is dropped and no res_valid is produced. rst has priority over clr and in_valid.

Structure
REQ-031 Shared package addsub_pkg SHALL hold:
- operand width 4 and result width 5;
- mode encodings ADD = 0, SUB = 1;
- the RUN/HALT state type.
REQ-032 The expected-value computation SHALL be one combinational sub-module, addsub_ref (m, a, b -> exp[4:0]), reusable by other benches.
REQ-033 All registers SHALL sit in addsub_checker; no latches, single clock domain.

Verification
REQ-034 Add pass:
- Stimulus: m=0, a=5, b=5, sum=01010.
- Response: res_valid one cycle later, res_pass = 1, pass_count = 1.
REQ-035 Subtract pass with wrap:
- Stimulus: m=1, a=0, b=2, sum=11110, then m=1, a=1010, b=0001, sum=01001.
- Response: two consecutive passes, pass_count = 2, err = 0.
REQ-036 Mismatch with halt:
- Stimulus: m=0, a=1011, b=1011, sum=00110 (expected 10110).
- Response: res_pass = 0, fail_count = 1, err = 1, fail_exp = 10110, in_ready = 0 from the next cycle.
- Further in_valid is ignored until clr.
REQ-037 HALT_ON_ERR = 0:
- Stimulus: two mismatches followed by one pass.
- Response: fail_count = 2, pass_count = 1, capture holds the first mismatch only.
REQ-038 Saturation:
- Stimulus: with CNT_W = 2, send 5 passing samples.
- Response: pass_count = 3.
REQ-039 Reset/clear mid-operation:
- Stimulus: rst in the cycle after acceptance.
- Response: no res_valid, all outputs at their reset values.
- Stimulus: clr coincident with a result.
- Response: counters remain 0.
